// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction-sequencing controller: state codes,
// opcodes, write-back mux selects and ALU select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ADD    = 4'd7,
    HALT   = 4'd8,
    SUB    = 4'd9,
    LDI    = 4'd10,
    JZ     = 4'd11
  } state_t;

  // Opcode occupies the top OP_W bits of the instruction word.
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_STORE = 4'd1;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OP_W-1:0] OP_HALT  = 4'd5;
  localparam logic [OP_W-1:0] OP_LDI   = 4'd6;
  localparam logic [OP_W-1:0] OP_JZ    = 4'd7;

  localparam logic [1:0] RF_S_ALU = 2'd0;
  localparam logic [1:0] RF_S_MEM = 2'd1;
  localparam logic [1:0] RF_S_IMM = 2'd2;

  localparam int ALU_PASS = 0;
  localparam int ALU_ADD  = 1;
  localparam int ALU_SUB  = 2;

endpackage

// File: rtl/ctrl_fsm_p.sv
// Parametrised instruction-sequencing controller: fetch, decode and execute
// with ready-stretched data-memory accesses, LDI and JZ.
module ctrl_fsm_p
  import ctrl_pkg::*;
#(
  parameter int IR_W   = 16,
  parameter int RF_AW  = 4,
  parameter int D_AW   = 8,
  parameter int PC_AW  = 8,
  parameter int ALU_SW = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [IR_W-1:0]   IR,
  input  logic              D_rdy,
  input  logic              RF_Ra_zero,
  output logic              PC_clr,
  output logic              PC_up,
  output logic              PC_ld,
  output logic [PC_AW-1:0]  PC_target,
  output logic              IR_Id,
  output logic [D_AW-1:0]   D_addr,
  output logic              D_wr,
  output logic [1:0]        RF_s,
  output logic [D_AW-1:0]   RF_imm,
  output logic [RF_AW-1:0]  RF_W_addr,
  output logic [RF_AW-1:0]  RF_Ra_addr,
  output logic [RF_AW-1:0]  RF_Rb_addr,
  output logic              RF_W_en,
  output logic [ALU_SW-1:0] ALU_s0,
  output logic              halted,
  output logic [3:0]        outputCurrentState,
  output logic [3:0]        outputNextState
);

  state_t state, next_state;

  logic [OP_W-1:0]  opcode;
  logic [RF_AW-1:0] field_a;
  logic [RF_AW-1:0] field_b;
  logic [RF_AW-1:0] field_d;
  logic [D_AW-1:0]  field_hi;
  logic [D_AW-1:0]  field_lo;
  logic [PC_AW-1:0] field_target;

  // field_hi is the LOAD address and the LDI immediate; field_lo is the STORE address.
  assign opcode       = IR[IR_W-1 -: OP_W];
  assign field_a      = IR[IR_W-1-OP_W -: RF_AW];
  assign field_b      = IR[IR_W-1-OP_W-RF_AW -: RF_AW];
  assign field_d      = IR[RF_AW-1:0];
  assign field_hi     = IR[IR_W-1-OP_W -: D_AW];
  assign field_lo     = IR[D_AW-1:0];
  assign field_target = IR[PC_AW-1:0];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = INIT;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    PC_ld      = 1'b0;
    PC_target  = '0;
    IR_Id      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = RF_S_ALU;
    RF_imm     = '0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    RF_W_en    = 1'b0;
    ALU_s0     = ALU_SW'(ALU_PASS);
    halted     = 1'b0;

    case (state)
      INIT: begin
        PC_clr     = 1'b1;
        next_state = FETCH;
      end
      FETCH: begin
        PC_up      = 1'b1;
        IR_Id      = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_STORE: next_state = STORE;
          OP_LOAD:  next_state = LOAD_A;
          OP_ADD:   next_state = ADD;
          OP_SUB:   next_state = SUB;
          OP_HALT:  next_state = HALT;
          OP_LDI:   next_state = LDI;
          OP_JZ:    next_state = JZ;
          default:  next_state = NOOP;
        endcase
      end
      NOOP: next_state = FETCH;
      LOAD_A, LOAD_B: begin
        D_addr    = field_hi;
        RF_s      = RF_S_MEM;
        RF_W_addr = field_d;
        if (state == LOAD_B) begin
          RF_W_en    = 1'b1;
          next_state = FETCH;
        end else begin
          next_state = D_rdy ? LOAD_B : LOAD_A;
        end
      end
      STORE: begin
        D_addr     = field_lo;
        D_wr       = 1'b1;
        RF_Ra_addr = field_a;
        next_state = D_rdy ? FETCH : STORE;
      end
      ADD, SUB: begin
        RF_Ra_addr = field_a;
        RF_Rb_addr = field_b;
        RF_W_addr  = field_d;
        RF_W_en    = 1'b1;
        ALU_s0     = (state == ADD) ? ALU_SW'(ALU_ADD) : ALU_SW'(ALU_SUB);
        next_state = FETCH;
      end
      LDI: begin
        RF_s       = RF_S_IMM;
        RF_imm     = field_hi;
        RF_W_addr  = field_d;
        RF_W_en    = 1'b1;
        next_state = FETCH;
      end
      JZ: begin
        RF_Ra_addr = field_a;
        // The load wins over the increment already applied in FETCH.
        if (RF_Ra_zero) begin
          PC_ld     = 1'b1;
          PC_target = field_target;
        end
        next_state = FETCH;
      end
      HALT: begin
        halted     = 1'b1;
        next_state = HALT;
      end
      default: next_state = INIT;
    endcase
  end

  assign outputCurrentState = state;
  assign outputNextState    = next_state;

endmodule
